// File: rtl/cgra_tile_pkg.sv
// Shared select codes, direction indices and select-width helper for the CGRA tile crossbar.
package cgra_tile_pkg;

    localparam int SEL_OFF      = 0;
    localparam int SEL_PE       = 1;
    localparam int SEL_BYP_BASE = 2;

    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_S = 2;
    localparam int DIR_W = 3;

    localparam int DEFAULT_NUM_PORTS = 4;

    // One code per port: OFF, PE, and one pass-through per input port.
    function automatic int sel_w(input int num_ports);
        return $clog2(num_ports + 2);
    endfunction

    typedef logic [sel_w(DEFAULT_NUM_PORTS)-1:0] sel_t;

endpackage

// File: rtl/cgra_elastic_fifo.sv
// Registered-storage elastic FIFO for one crossbar output port.
module cgra_elastic_fifo
    import cgra_tile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push_i,
    input  logic [DATA_WIDTH-1:0]               data_i,
    output logic                                space_o,
    input  logic                                pop_i,
    output logic [DATA_WIDTH-1:0]               data_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    // No full-and-dequeue pass-through: space depends on the registered count only.
    assign space_o = (count_q < CNT_W'(FIFO_DEPTH));
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        do_push  = push_i && space_o;
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cgra_tile_xbar_out.sv
// CGRA tile output crossbar: per-context port selects, fork handshakes, elastic output FIFOs.
// Optional per-port back-pressure counters are built when CGRA_XBAR_PERF_EN is defined.
module cgra_tile_xbar_out
    import cgra_tile_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_PORTS     = 4,
    parameter int FIFO_DEPTH    = 2,
    parameter int CONTEXT_DEPTH = 16,
    parameter int PC_WIDTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PC_WIDTH-1:0]               context_pc,
    input  logic                              global_stall,
    input  logic                              cfg_wr_en,
    input  logic [PC_WIDTH-1:0]               cfg_wr_addr,
    input  logic [NUM_PORTS*sel_w(NUM_PORTS)-1:0] cfg_wr_data,
    input  logic [DATA_WIDTH-1:0]             pe_data,
    input  logic                              pe_valid,
    output logic                              pe_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   byp_data,
    input  logic [NUM_PORTS-1:0]              byp_valid,
    output logic [NUM_PORTS-1:0]              byp_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   data_out,
    output logic [NUM_PORTS-1:0]              valid_out,
    input  logic [NUM_PORTS-1:0]              ready_in,
    output logic [NUM_PORTS*32-1:0]           bp_count
);

    localparam int SEL_W   = sel_w(NUM_PORTS);
    localparam int CFG_W   = NUM_PORTS * SEL_W;
    localparam int NUM_SRC = NUM_PORTS + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    logic [CFG_W-1:0]                     cfg_q [CONTEXT_DEPTH];
    logic [CFG_W-1:0]                     cfg_rd;
    logic [NUM_PORTS-1:0][NUM_SRC-1:0]    sel_hot;
    logic [NUM_SRC-1:0]                   src_valid;
    logic [NUM_SRC-1:0]                   src_ready;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data;
    logic [NUM_PORTS-1:0]                 space;
    logic [NUM_PORTS-1:0]                 push;
    logic [NUM_PORTS-1:0]                 pop;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] push_data;
    logic [NUM_PORTS-1:0][CNT_W-1:0]      count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CONTEXT_DEPTH; i++) begin
                cfg_q[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            cfg_q[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    assign cfg_rd = cfg_q[context_pc];

    // Source 0 is the PE, source 1+k is pass-through k; a port selects source s with code s+1.
    always_comb begin
        src_valid[0] = pe_valid;
        src_data[0]  = pe_data;
        for (int k = 0; k < NUM_PORTS; k++) begin
            src_valid[k+1] = byp_valid[k];
            src_data[k+1]  = byp_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                sel_hot[p][s] = (int'(cfg_rd[p*SEL_W +: SEL_W]) == s + SEL_PE);
            end
        end
    end

    // Fork readiness never looks at same-cycle valids, so all selected FIFOs accept together.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            logic used;
            logic all_space;
            used      = 1'b0;
            all_space = 1'b1;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sel_hot[p][s]) begin
                    used      = 1'b1;
                    all_space = all_space && space[p];
                end
            end
            src_ready[s] = !global_stall && used && all_space;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            push[p]      = |(sel_hot[p] & src_valid & src_ready);
            push_data[p] = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (sel_hot[p][s]) begin
                    push_data[p] = src_data[s];
                end
            end
        end
    end

    assign pe_ready  = src_ready[0];
    assign byp_ready = src_ready[NUM_SRC-1:1];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        cgra_elastic_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[p]),
            .data_i  (push_data[p]),
            .space_o (space[p]),
            .pop_i   (pop[p]),
            .data_o  (data_out[p*DATA_WIDTH +: DATA_WIDTH]),
            .count_o (count[p])
        );

        assign valid_out[p] = (count[p] != '0);
        assign pop[p]       = valid_out[p] && ready_in[p];
    end

`ifdef CGRA_XBAR_PERF_EN
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_perf
        logic [31:0] bp_q, bp_d;

        // Saturates at all-ones so a long stall never wraps back to a small value.
        always_comb begin
            bp_d = bp_q;
            if (valid_out[p] && !ready_in[p] && (bp_q != 32'hFFFF_FFFF)) begin
                bp_d = bp_q + 32'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bp_q <= '0;
            end else begin
                bp_q <= bp_d;
            end
        end

        assign bp_count[p*32 +: 32] = bp_q;
    end
`else
    assign bp_count = '0;
`endif

endmodule

// File: tb/tb_cgra_tile_xbar_out.sv
// Directed bench for cgra_tile_xbar_out: vector table plus hand-written fork/config/stall/perf sequences.
module tb_cgra_tile_xbar_out;
  import cgra_tile_pkg::*;

  localparam int DW = 32;
  localparam int NP = 4;

  logic           clk;
  logic           rst_n;
  logic [3:0]     context_pc;
  logic           global_stall;
  logic           cfg_wr_en;
  logic [3:0]     cfg_wr_addr;
  logic [11:0]    cfg_wr_data;
  logic [DW-1:0]  pe_data;
  logic           pe_valid;
  logic           pe_ready;
  logic [127:0]   byp_data;
  logic [3:0]     byp_valid;
  logic [3:0]     byp_ready;
  logic [127:0]   data_out;
  logic [3:0]     valid_out;
  logic [3:0]     ready_in;
  logic [127:0]   bp_count;

  int n_cmp = 0;
  int n_mis = 0;

  cgra_tile_xbar_out dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .context_pc   (context_pc),
    .global_stall (global_stall),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .pe_data      (pe_data),
    .pe_valid     (pe_valid),
    .pe_ready     (pe_ready),
    .byp_data     (byp_data),
    .byp_valid    (byp_valid),
    .byp_ready    (byp_ready),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .bp_count     (bp_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    n_mis++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]   ctx;
    logic         stall;
    logic         pv;
    logic [31:0]  pd;
    logic [3:0]   bv;
    logic [31:0]  bw;
    logic [3:0]   rdy;
    logic         exp_pe_ready;
    logic [3:0]   exp_byp_ready;
    logic [3:0]   exp_valid;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ports(input string name, input logic [3:0] ev, input logic [127:0] ed);
    chk({name, "_valid"}, 128'(valid_out), 128'(ev));
    for (int p = 0; p < NP; p++) begin
      if (ev[p]) begin
        chk($sformatf("%s_data%0d", name, p), 128'(data_out[p*DW +: DW]), 128'(ed[p*DW +: DW]));
      end
    end
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [11:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = addr;
    cfg_wr_data = data;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] ctx, input logic stall, input logic pv,
                              input logic [31:0] pd, input logic [3:0] bv, input logic [31:0] bw,
                              input logic [3:0] rdy, input logic epr, input logic [3:0] ebr,
                              input logic [3:0] ev, input logic [127:0] ed);
    vec_t v;
    v.ctx = ctx; v.stall = stall; v.pv = pv; v.pd = pd; v.bv = bv; v.bw = bw; v.rdy = rdy;
    v.exp_pe_ready = epr; v.exp_byp_ready = ebr; v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  function automatic logic [127:0] rep4(input logic [31:0] w);
    return {w, w, w, w};
  endfunction

  // Select words: 3 bits per port, port p at [p*3 +: 3].
  localparam logic [11:0] CFG_ALL_PE = 12'h249;
  localparam logic [11:0] CFG_CTX1   = 12'h00C; // N=BYP(S), E=PE
  localparam logic [11:0] CFG_E_OFF  = 12'h241;
  localparam logic [11:0] CFG_W_PE   = 12'h200;

  initial begin
    rst_n = 1'b1; context_pc = '0; global_stall = 1'b0; cfg_wr_en = 1'b0;
    cfg_wr_addr = '0; cfg_wr_data = '0; pe_data = '0; pe_valid = 1'b0;
    byp_data = '0; byp_valid = '0; ready_in = 4'hF;
    #2 rst_n = 1'b0;
    #8;
    chk("rst_valid_out", 128'(valid_out), 128'(0));
    chk("rst_data_out", data_out, 128'(0));
    chk("rst_pe_ready", 128'(pe_ready), 128'(0));
    chk("rst_byp_ready", 128'(byp_ready), 128'(0));
    chk("rst_bp_count", bp_count, 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    cfg_write(4'd0, CFG_ALL_PE);
    cfg_write(4'd1, CFG_CTX1);

    vecs[0] = mk(4'd0, 0, 1, 32'hA5, 4'h0, 32'h0,    4'hF, 1, 4'h0, 4'h0, rep4(32'h0));
    vecs[1] = mk(4'd0, 0, 0, 32'h0,  4'h0, 32'h0,    4'hF, 1, 4'h0, 4'hF, rep4(32'hA5));
    vecs[2] = mk(4'd0, 0, 0, 32'h0,  4'h0, 32'h0,    4'hF, 1, 4'h0, 4'h0, rep4(32'h0));
    vecs[3] = mk(4'd1, 0, 1, 32'h55, 4'h4, 32'h1234, 4'hF, 1, 4'h4, 4'h0, rep4(32'h0));
    vecs[4] = mk(4'd1, 0, 0, 32'h0,  4'h0, 32'h0,    4'hF, 1, 4'h4, 4'h3,
                 {32'h0, 32'h0, 32'h55, 32'h1234});
    vecs[5] = mk(4'd1, 1, 1, 32'h66, 4'h4, 32'h77,   4'hF, 0, 4'h0, 4'h0, rep4(32'h0));
    vecs[6] = mk(4'd1, 0, 0, 32'h0,  4'h0, 32'h0,    4'hF, 1, 4'h4, 4'h0, rep4(32'h0));

    for (int i = 0; i < 7; i++) begin
      context_pc = vecs[i].ctx; global_stall = vecs[i].stall;
      pe_valid = vecs[i].pv; pe_data = vecs[i].pd;
      byp_valid = vecs[i].bv; byp_data = rep4(vecs[i].bw); ready_in = vecs[i].rdy;
      settle();
      chk($sformatf("vec%0d_pe_ready", i), 128'(pe_ready), 128'(vecs[i].exp_pe_ready));
      chk($sformatf("vec%0d_byp_ready", i), 128'(byp_ready), 128'(vecs[i].exp_byp_ready));
      chk_ports($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data);
      tick();
    end
    byp_valid = '0; byp_data = '0;

    // Fork stall: E blocked, three words offered to all ports.
    context_pc = 4'd0; ready_in = 4'b1101; pe_valid = 1'b1; pe_data = 32'h11;
    settle(); chk("fork_c0_pe_ready", 128'(pe_ready), 128'(1));
    tick();
    pe_data = 32'h22;
    settle(); chk("fork_c1_pe_ready", 128'(pe_ready), 128'(1));
    chk_ports("fork_c1", 4'hF, rep4(32'h11));
    tick();
    pe_data = 32'h33;
    settle(); chk("fork_c2_pe_ready", 128'(pe_ready), 128'(0));
    chk_ports("fork_c2", 4'hF, {32'h22, 32'h22, 32'h11, 32'h22});
    tick();
    settle(); chk("fork_c3_pe_ready", 128'(pe_ready), 128'(0));
    chk_ports("fork_c3", 4'b0010, {32'h0, 32'h0, 32'h11, 32'h0});
    tick();
    ready_in = 4'hF;
    settle(); chk("fork_c4_pe_ready", 128'(pe_ready), 128'(0));
    chk_ports("fork_c4", 4'b0010, {32'h0, 32'h0, 32'h11, 32'h0});
    tick();
    settle(); chk("fork_c5_pe_ready", 128'(pe_ready), 128'(1));
    chk_ports("fork_c5", 4'b0010, {32'h0, 32'h0, 32'h22, 32'h0});
    tick();
    pe_valid = 1'b0;
    settle(); chk_ports("fork_c6", 4'hF, rep4(32'h33));
    tick();
    settle(); chk_ports("fork_c7", 4'h0, rep4(32'h0));
    tick();

    // Rewrite the active context: E switches PE -> OFF.
    cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_data = CFG_E_OFF;
    pe_valid = 1'b1; pe_data = 32'hD1;
    settle(); chk("cfgw_c0_pe_ready", 128'(pe_ready), 128'(1));
    tick();
    cfg_wr_en = 1'b0; pe_data = 32'hD2;
    settle(); chk("cfgw_c1_pe_ready", 128'(pe_ready), 128'(1));
    chk_ports("cfgw_c1", 4'hF, rep4(32'hD1));
    tick();
    pe_valid = 1'b0;
    settle(); chk_ports("cfgw_c2", 4'b1101, rep4(32'hD2));
    tick();
    settle(); chk_ports("cfgw_c3", 4'h0, rep4(32'h0));
    tick();

    // Global stall drains two buffered words.
    ready_in = 4'h0; pe_valid = 1'b1; pe_data = 32'hC1;
    settle(); chk("stall_c0_pe_ready", 128'(pe_ready), 128'(1));
    tick();
    pe_data = 32'hC2;
    settle(); chk("stall_c1_pe_ready", 128'(pe_ready), 128'(1));
    tick();
    global_stall = 1'b1; ready_in = 4'hF; pe_data = 32'hC3;
    settle(); chk("stall_c2_pe_ready", 128'(pe_ready), 128'(0));
    chk_ports("stall_c2", 4'b1101, rep4(32'hC1));
    tick();
    settle(); chk("stall_c3_pe_ready", 128'(pe_ready), 128'(0));
    chk_ports("stall_c3", 4'b1101, rep4(32'hC2));
    tick();
    settle(); chk("stall_c4_pe_ready", 128'(pe_ready), 128'(0));
    chk_ports("stall_c4", 4'h0, rep4(32'h0));
    tick();
    global_stall = 1'b0; pe_valid = 1'b0;
    settle(); chk("stall_c5_pe_ready", 128'(pe_ready), 128'(1));
    tick();

    // Back-pressure on W for 10 cycles, then asynchronous reset mid-cycle.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle(); chk("rst2_pe_ready", 128'(pe_ready), 128'(0));
    tick();
    cfg_write(4'd0, CFG_W_PE);
    ready_in = 4'b0111; pe_valid = 1'b1; pe_data = 32'h77;
    settle(); chk("bp_push_pe_ready", 128'(pe_ready), 128'(1));
    tick();
    pe_valid = 1'b0;
    repeat (10) tick();
    settle();
    chk_ports("bp_hold", 4'b1000, {32'h77, 32'h0, 32'h0, 32'h0});
`ifdef CGRA_XBAR_PERF_EN
    chk("bp_count_w", 128'(bp_count[DIR_W*32 +: 32]), 128'(10));
`else
    chk("bp_count_w", 128'(bp_count[DIR_W*32 +: 32]), 128'(0));
`endif
    chk("bp_count_nes", 128'(bp_count[95:0]), 128'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid_out", 128'(valid_out), 128'(0));
    chk("arst_bp_count", bp_count, 128'(0));
    chk("arst_data_out", data_out, 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
